// File: rtl/dff_wr_arbiter_pkg.sv
// Shared definitions for dff_wr_arbiter: FSM encoding, N_REQ limits, index width helper.
package dff_wr_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_ACK   = 2'd2
  } state_e;

  localparam int unsigned N_REQ_MIN = 2;
  localparam int unsigned N_REQ_MAX = 8;

  // Bits needed to hold a requester index (at least one).
  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dff_wr_arbiter_if.sv
// Requester-side bus of dff_wr_arbiter: requests, data slices, grant/ack and storage view.
interface dff_wr_arbiter_if #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned DATA_W = 8
);
  logic                      enable;
  logic [N_REQ-1:0]          req;
  logic [N_REQ*DATA_W-1:0]   data;
  logic [N_REQ-1:0]          gnt;
  logic [N_REQ-1:0]          ack;
  logic                      wr_en;
  logic                      busy;
  logic [DATA_W-1:0]         q;

  modport master (
    output enable, req, data,
    input  gnt, ack, wr_en, busy, q
  );

  modport slave (
    input  enable, req, data,
    output gnt, ack, wr_en, busy, q
  );
endinterface

// File: rtl/dff_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after index 'last', with wrap.
module dff_wr_arbiter_rr_pick
  import dff_wr_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic [N_REQ-1:0] onehot,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W:0] cand;
  logic           found;

  // Walk last+1 .. last+N_REQ modulo N_REQ and keep the first requester seen.
  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    cand   = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      cand = (IDX_W+1)'(last) + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(N_REQ)) begin
        cand = cand - (IDX_W+1)'(N_REQ);
      end
      if (!found && req[cand[IDX_W-1:0]]) begin
        found                    = 1'b1;
        onehot[cand[IDX_W-1:0]]  = 1'b1;
        idx                      = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/dff_wr_arbiter.sv
// Round-robin write arbiter owning a shared enable-gated storage register.
// Optional build macro DFF_WR_ARB_PRIO_EN: requester 0 becomes fixed high priority.
module dff_wr_arbiter
  import dff_wr_arbiter_pkg::*;
#(
  parameter int unsigned       N_REQ     = 4,
  parameter int unsigned       DATA_W    = 8,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic               i_clk,
  input  logic               i_rst,
  dff_wr_arbiter_if.slave    bus
);

  localparam int unsigned IDX_W = idx_w(N_REQ);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);

  if (N_REQ < N_REQ_MIN || N_REQ > N_REQ_MAX) begin : g_bad_n_req
    $error("dff_wr_arbiter: N_REQ must be within 2..8");
  end

  state_e             state_q, state_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [N_REQ-1:0]   ack_q, ack_d;
  logic               wr_en_q, wr_en_d;
  logic               busy_q, busy_d;
  logic [DATA_W-1:0]  q_q, q_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [IDX_W-1:0]   win_q, win_d;
  logic               prio_q, prio_d;

  logic [N_REQ-1:0]   rr_req;
  logic [N_REQ-1:0]   pick_onehot;
  logic [IDX_W-1:0]   pick_idx;
  logic [N_REQ-1:0]   sel_onehot;
  logic [IDX_W-1:0]   sel_idx;
  logic               sel_prio;

  dff_wr_arbiter_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req    (rr_req),
    .last   (last_q),
    .onehot (pick_onehot),
    .idx    (pick_idx)
  );

`ifdef DFF_WR_ARB_PRIO_EN
  // Requester 0 preempts the rotation; the others rotate among themselves.
  always_comb begin
    rr_req     = bus.req & ~N_REQ'(1);
    sel_onehot = pick_onehot;
    sel_idx    = pick_idx;
    sel_prio   = 1'b0;
    if (bus.req[0]) begin
      sel_onehot = N_REQ'(1);
      sel_idx    = '0;
      sel_prio   = 1'b1;
    end
  end
`else
  // Pure rotation across all requesters.
  always_comb begin
    rr_req     = bus.req;
    sel_onehot = pick_onehot;
    sel_idx    = pick_idx;
    sel_prio   = 1'b0;
  end
`endif

  // State and registered outputs; reset drops any in-flight write.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      ack_q   <= '0;
      wr_en_q <= 1'b0;
      busy_q  <= 1'b0;
      q_q     <= RESET_VAL;
      last_q  <= LAST_RST;
      win_q   <= '0;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      wr_en_q <= wr_en_d;
      busy_q  <= busy_d;
      q_q     <= q_d;
      last_q  <= last_d;
      win_q   <= win_d;
      prio_q  <= prio_d;
    end
  end

  // Next state and next register values for IDLE -> GRANT -> ACK sequencing.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ack_d   = '0;
    wr_en_d = 1'b0;
    busy_d  = 1'b0;
    q_d     = q_q;
    last_d  = last_q;
    win_d   = win_q;
    prio_d  = prio_q;
    case (state_q)
      ST_IDLE: begin
        gnt_d = '0;
        if (bus.enable && (|bus.req)) begin
          gnt_d   = sel_onehot;
          win_d   = sel_idx;
          prio_d  = sel_prio;
          wr_en_d = 1'b1;
          busy_d  = 1'b1;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        q_d     = bus.data[32'(win_q)*DATA_W +: DATA_W];
        if (!prio_q) begin
          last_d = win_q;
        end
        ack_d   = gnt_q;
        busy_d  = 1'b1;
        state_d = ST_ACK;
      end
      ST_ACK: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.gnt   = gnt_q;
  assign bus.ack   = ack_q;
  assign bus.wr_en = wr_en_q;
  assign bus.busy  = busy_q;
  assign bus.q     = q_q;

endmodule
